// File: rtl/gauss_series.sv
// Gauss series engine: computes the sum of i (mode 0) or the sum of i*i
// (mode 1) for i = 1..n, one term per clock, with a sticky overflow flag
// and a tri-stateable result bus.
module gauss_series #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  input  logic             oe,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [WIDTH-1:0] result
);

  // i needs one extra bit so that i can step past n = 2^WIDTH-1 and end the loop.
  localparam int IW = WIDTH + 1;
  // term holds up to (2^WIDTH)^2 plus the 2i+1 increment without wrapping.
  localparam int TW = 2 * WIDTH + 2;
  // Exact accumulate width: acum + term can carry one bit past term.
  localparam int SW = TW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q,     n_d;
  logic             mode_q,  mode_d;
  logic [WIDTH-1:0] acum_q,  acum_d;
  logic [IW-1:0]    i_q,     i_d;
  logic [TW-1:0]    term_q,  term_d;
  logic             ovf_q,   ovf_d;

  // Helper values for the accumulate step, computed at full precision.
  logic [SW-1:0]    sum_exact;
  logic             in_range;
  logic [TW-1:0]    i_ext;

  // Full-precision datapath terms used by the next-state logic.
  always_comb begin
    i_ext     = TW'(i_q);
    sum_exact = SW'(acum_q) + SW'(term_q);
    in_range  = (i_q <= IW'(n_q));
  end

  // Next-state and datapath update for the three-state controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    n_d     = n_q;
    mode_d  = mode_q;
    acum_d  = acum_q;
    i_d     = i_q;
    term_d  = term_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOOP;
          n_d     = data;
          mode_d  = mode;
          acum_d  = '0;
          i_d     = IW'(1);
          term_d  = TW'(1);
          ovf_d   = 1'b0;
        end
      end

      LOOP: begin
        if (in_range) begin
          acum_d = sum_exact[WIDTH-1:0];
          i_d    = i_q + IW'(1);
          if (sum_exact[SW-1:WIDTH] != '0) begin
            ovf_d = 1'b1;
          end
          // Mode 1 keeps term == i*i using (i+1)^2 = i^2 + 2i + 1.
          if (mode_q) begin
            term_d = term_q + (i_ext << 1) + TW'(1);
          end else begin
            term_d = i_ext + TW'(1);
          end
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      mode_q  <= 1'b0;
      acum_q  <= '0;
      i_q     <= '0;
      term_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      acum_q  <= acum_d;
      i_q     <= i_d;
      term_q  <= term_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state_q == LOOP);
    done = (state_q == DONE);
    ovf  = ovf_q;
  end

  // Result bus is released to high impedance when not enabled.
  assign result = oe ? acum_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_gauss_series.sv
// Directed self-checking bench for gauss_series at WIDTH=8.
module tb_gauss_series;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] data;
  logic         oe;
  logic         busy;
  logic         done;
  logic         ovf;
  wire  [W-1:0] result;

  int errors;
  int checks;

  gauss_series #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .data   (data),
    .oe     (oe),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .result (result)
  );

  // Weak pull-ups give the released bus a defined value in any simulator.
  for (genvar b = 0; b < W; b++) begin : g_pu
    pullup (result[b]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start and count edges after the accept edge until done.
  // busy_cnt counts samples with busy=1, starting right after the accept edge.
  task automatic run(input logic m, input logic [W-1:0] n, input int budget,
                     output int edges, output int busy_cnt);
    start = 1'b1;
    mode  = m;
    data  = n;
    tick();
    start    = 1'b0;
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < budget) begin
      tick();
      edges++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 1'b0; data = 8'd5; oe = 1'b1;
    tick();
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
  endtask

  task automatic test_sum();
    int e, b;
    run(1'b0, 8'd4, 50, e, b);
    checks++; if (e !== 5) begin errors++; $display("FAIL sum4_latency got=%0d exp=5", e); end
    checks++; if (b !== 5) begin errors++; $display("FAIL sum4_busy_cycles got=%0d exp=5", b); end
    checks++; if (result !== 8'd10) begin errors++; $display("FAIL sum4_result got=%0d exp=10", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sum4_ovf got=%b exp=0", ovf); end
    // DONE holds with start low.
    tick(); tick(); tick();
    checks++; if (done !== 1'b1 || result !== 8'd10) begin
      errors++; $display("FAIL done_hold got done=%b result=%0d exp done=1 result=10", done, result);
    end
  endtask

  task automatic test_partial();
    start = 1'b1; mode = 1'b0; data = 8'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (result !== 8'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL partial_sum got result=%0d busy=%b exp result=3 busy=1", result, busy);
    end
    repeat (4) tick();
    checks++; if (result !== 8'd10 || done !== 1'b1) begin
      errors++; $display("FAIL partial_final got result=%0d done=%b exp result=10 done=1", result, done);
    end
  endtask

  task automatic test_squares();
    int e, b;
    run(1'b1, 8'd3, 50, e, b);
    checks++; if (e !== 4) begin errors++; $display("FAIL sq3_latency got=%0d exp=4", e); end
    checks++; if (result !== 8'd14) begin errors++; $display("FAIL sq3_result got=%0d exp=14", result); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sq3_ovf got=%b exp=0", ovf); end
    run(1'b1, 8'd0, 50, e, b);
    checks++; if (e !== 1) begin errors++; $display("FAIL sq0_latency got=%0d exp=1", e); end
    checks++; if (result !== 8'd0) begin errors++; $display("FAIL sq0_result got=%0d exp=0", result); end
    run(1'b1, 8'd5, 50, e, b);
    checks++; if (result !== 8'd55) begin errors++; $display("FAIL sq5_result got=%0d exp=55", result); end
  endtask

  task automatic test_overflow();
    int e, b;
    run(1'b0, 8'd22, 50, e, b);
    checks++; if (result !== 8'd253 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf22 got result=%0d ovf=%b exp result=253 ovf=0", result, ovf);
    end
    run(1'b0, 8'd23, 50, e, b);
    checks++; if (result !== 8'd20 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf23 got result=%0d ovf=%b exp result=20 ovf=1", result, ovf);
    end
    run(1'b0, 8'd2, 50, e, b);
    checks++; if (result !== 8'd3 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got result=%0d ovf=%b exp result=3 ovf=0", result, ovf);
    end
    // 1+4+9+16+25+36+49+64+81 = 285 -> 29, crossing 256 on the last term.
    run(1'b1, 8'd9, 50, e, b);
    checks++; if (result !== 8'd29 || ovf !== 1'b1) begin
      errors++; $display("FAIL sq_ovf got result=%0d ovf=%b exp result=29 ovf=1", result, ovf);
    end
  endtask

  task automatic test_max();
    int e, b;
    run(1'b0, 8'd255, 300, e, b);
    checks++; if (e !== 256) begin errors++; $display("FAIL max_latency got=%0d exp=256", e); end
    // 255*256/2 = 32640 -> 32640 mod 256 = 128.
    checks++; if (result !== 8'd128 || ovf !== 1'b1) begin
      errors++; $display("FAIL max_result got result=%0d ovf=%b exp result=128 ovf=1", result, ovf);
    end
  endtask

  task automatic test_abort();
    int e, b;
    int seen;
    start = 1'b1; mode = 1'b0; data = 8'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
      errors++; $display("FAIL abort_state got busy=%b done=%b result=%0d exp 0/0/0", busy, done, result);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    run(1'b0, 8'd3, 50, e, b);
    checks++; if (result !== 8'd6 || e !== 4) begin
      errors++; $display("FAIL abort_rerun got result=%0d edges=%0d exp result=6 edges=4", result, e);
    end
  endtask

  task automatic test_start_held();
    int e;
    start = 1'b1; mode = 1'b0; data = 8'd4;
    tick();
    // Hold start and disturb data/mode while looping.
    data = 8'd9; mode = 1'b1;
    tick(); tick(); tick();
    start = 1'b0;
    e = 3;
    while (!done && e < 50) begin
      tick();
      e++;
    end
    checks++; if (result !== 8'd10 || e !== 5) begin
      errors++; $display("FAIL start_held got result=%0d edges=%0d exp result=10 edges=5", result, e);
    end
  endtask

  task automatic test_back_to_back();
    // In DONE with result 10 from the previous test.
    oe = 1'b0;
    #1;
    checks++; if (result !== 8'hff && result !== 8'hzz) begin
      errors++; $display("FAIL oe_release got=%h exp=released", result);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL oe_done got=%b exp=1", done); end
    oe = 1'b1;
    #1;
    checks++; if (result !== 8'd10) begin errors++; $display("FAIL oe_restore got=%0d exp=10", result); end
    start = 1'b1; mode = 1'b0; data = 8'd1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_accept got done=%b busy=%b exp done=0 busy=1", done, busy);
    end
    tick();
    tick();
    checks++; if (done !== 1'b1 || result !== 8'd1) begin
      errors++; $display("FAIL restart_result got done=%b result=%0d exp done=1 result=1", done, result);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0; start = 1'b0; mode = 1'b0; data = '0; oe = 1'b1;
    test_reset();
    test_sum();
    test_partial();
    test_squares();
    test_overflow();
    test_max();
    test_abort();
    test_start_held();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gauss_series.md
GAUSS_SERIES -- requirements
Module: gauss_series

Interface
REQ-001 Parameter: WIDTH, default 16, operand and result width in bits (WIDTH >= 4).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to begin a computation; sampled only in IDLE or DONE.
REQ-005 mode  input  1  series select: 0 = sum of i, 1 = sum of i*i; sampled with start.
REQ-006 data  input  WIDTH  upper bound n; sampled with start.
REQ-007 oe  input  1  result output enable.
REQ-008 busy  output  1  high while a computation is in progress (state LOOP).
REQ-009 done  output  1  high while the result is valid (state DONE).
REQ-010 ovf  output  1  sticky overflow flag for the current/last computation.
REQ-011 result  output  WIDTH  accumulated sum; driven when oe=1, high-impedance on every bit when oe=0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, LOOP, DONE.
REQ-013 IDLE/DONE + start=1 -> LOOP; on that edge: n<=data, mode latched, acum<=0, i<=1, term<=1, ovf<=0.
REQ-014 IDLE + start=0 -> IDLE; DONE + start=0 -> DONE, with acum, ovf and done held.
REQ-015 LOOP with i<=n: acum<=acum+term (modulo 2^WIDTH), i<=i+1, state stays LOOP.
REQ-016 Term update: mode 0 -> term<=i+1; mode 1 -> term<=term+2i+1, so term always equals i*i.
REQ-017 LOOP with i>n -> DONE; acum, i and term unchanged on that edge.
REQ-018 i SHALL be WIDTH+1 bits wide, so the loop terminates when n=2^WIDTH-1.
REQ-019 term SHALL be 2*WIDTH+2 bits wide, so no term update wraps.
REQ-020 ovf SHALL be set on any LOOP accumulate edge where the exact acum+term >= 2^WIDTH, and stays set until the next accepted start or rst.
REQ-021 Latency: done rises on the (n+1)th rising edge after the start-accept edge; n=0 gives done after 1 edge with result 0.
REQ-022 start while in LOOP SHALL be ignored; data and mode changes during LOOP SHALL have no effect.
REQ-023 start in DONE SHALL restart immediately; done deasserts on the accept edge.
REQ-024 busy = (state==LOOP) and done = (state==DONE), both decoded combinationally from the state register.
REQ-025 result SHALL reflect acum in every state when oe=1, including partial sums during LOOP; valid only while done=1.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE, acum=0, i=0, term=0, n=0 and ovf=0, overriding start.
REQ-027 After reset: busy=0, done=0, ovf=0, result=0 when oe=1.
REQ-028 rst asserted mid-LOOP SHALL abort the computation with no done pulse; the next start computes from scratch.

Verification (WIDTH=8 unless noted)
REQ-029 start, mode=0, data=4, oe=1 -> busy for 5 cycles, done on 5th edge, result=10, ovf=0.
REQ-030 start, mode=1, data=3 -> done on 4th edge, result=14, ovf=0; data=0 -> done on 1st edge, result=0.
REQ-031 mode=0, data=22 -> result=253, ovf=0; data=23 -> result=20 (276 mod 256), ovf=1; next start with data=2 -> result=3, ovf=0.
REQ-032 mode=0, data=255 -> terminates, done on 256th edge, ovf=1, no hang.
REQ-033 rst pulse at cycle 3 of data=10 run -> IDLE, busy=0, done never asserts; start with start held during LOOP -> ignored, same result as a single pulse.
REQ-034 oe=0 in DONE -> result all Z; oe=1 -> value restored unchanged; start in DONE with data=1 -> result=1 after 2 edges.
